rx_edge_bit_sampler: RTL and testbench
======================================

# rx_edge_bit_sampler

Timing and sampling stage of the UART receiver, sitting directly beside the receive control FSM. It generates the per-bit oversampling edge count (`edge_cnt`) and the frame bit index (`bit_cnt`) that the FSM consumes. It also produces a majority-voted, registered sample of `RX_IN` for each bit period, which the deserializer and the start, parity and stop checkers use.

## Interface
- `EDGE_W`, default 6: width of `edge_cnt` and `prescale`.
- `BIT_W`, default 4: width of `bit_cnt`.
- `clk`  in  1  receiver oversampling clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, already synchronized to `clk` at top level.
- `enable`  in  1  from FSM; high while a frame is in progress.
- `dat_samp_en`  in  1  from FSM; permits sample capture.
- `prescale`  in  EDGE_W  oversampling ratio. Legal values are 8, 16 and 32. It is static while `enable` is high.
- `edge_cnt`  out  EDGE_W  position within the current bit period, 0..P-1.
- `bit_cnt`  out  BIT_W  index of the current frame bit (0 = start bit).
- `sampled_bit`  out  1  majority-voted value of the current bit.
- `sample_valid`  out  1  single-cycle pulse: `sampled_bit` was updated this cycle.

## Operation
- Effective ratio P = `prescale` when `prescale` ≥ 8; otherwise P = 8. Half point H = P >> 1.
- **Edge counter:**
  - While `enable` is high, `edge_cnt` increments each cycle.
  - When `edge_cnt` == P-1, it wraps to 0 on the next edge.
  - When `enable` is low, `edge_cnt` clears to 0 on the next edge.
- **Bit counter:**
  - While `enable` is high and `edge_cnt` == P-1, `bit_cnt` increments on the next edge.
  - It saturates at 2^BIT_W − 1 and does not wrap.
  - When `enable` is low, it clears to 0 on the next edge.
- **Sampler:**
  - With `dat_samp_en` high, `RX_IN` is captured into s0 at `edge_cnt` == H-3, s1 at H-2 and s2 at H-1.
  - On the edge that ends the `edge_cnt` == H-1 cycle, `sampled_bit` <= maj(s0, s1, s2), i.e. (s0&s1)|(s0&s2)|(s1&s2).
  - `sample_valid` is registered: it is high for exactly the one cycle in which `edge_cnt` == H and `sampled_bit` holds the new value.
  - With `dat_samp_en` low, no capture occurs, `sampled_bit` holds its value, and `sample_valid` is 0 even if `edge_cnt` passes H.
  - Each sample register is overwritten only at its own capture point; stale samples from the previous bit are never mixed in once all three points have been passed.
- **Simultaneous events:**
  - `enable` falling in the same cycle as `edge_cnt` == P-1: the clear takes priority, so both counters are 0 next cycle.
  - `enable` low with `dat_samp_en` high: counters clear; capture happens only at matching `edge_cnt` values.
- **Restart:** back-to-back frames. The FSM drops `enable` for at least one cycle or keeps it high across STOP→START. When `enable` stays high, counting simply continues, so the FSM is responsible for restart behaviour; the block is not.
- **Reset:**
  - Values: `edge_cnt` = 0, `bit_cnt` = 0, s0/s1/s2 = 1, `sampled_bit` = 1 (idle line level), `sample_valid` = 0.
  - Reset asserted mid-frame returns all outputs to these values immediately (asynchronously).

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `edge_cnt` reads 0 in the first cycle `enable` is high, then 1, 2, ….
- Bit period = P cycles. Bit k occupies `edge_cnt` 0..P-1 while `bit_cnt` == k.
- Sample latency: the last capture is at H-1 and the result is visible at H. `sampled_bit` is therefore stable from `edge_cnt` == H through H-1 of the next bit. This covers the FSM's parity strobe at H and deserializer strobe at H+1.
- P = 8: samples at 1, 2, 3; valid at 4. P = 16: samples at 5, 6, 7; valid at 8. P = 32: samples at 13, 14, 15; valid at 16.

## Test plan
- **Basic count, P = 16:** `enable` high for 48 cycles, then low → `edge_cnt` sequence 0..15 three times; `bit_cnt` 0, 1, 2; both counters 0 one cycle after `enable` falls.
- **Majority vote, P = 8:** `dat_samp_en` = 1, `RX_IN` = 0, 1, 0 at `edge_cnt` 1, 2, 3 → `sampled_bit` = 0 and `sample_valid` = 1 at `edge_cnt` 4. Pattern 1, 0, 1 → `sampled_bit` = 1.
- **Full frame 0x A5, P = 32, no parity:** drive start, LSB-first data and stop bits → `sample_valid` pulses at `edge_cnt` 16 of `bit_cnt` 0..9; `sampled_bit` sequence 0,1,0,1,0,0,1,0,1,1.
- **Saturation and clamp:**
  - `prescale` = 4 → behaves as P = 8.
  - `enable` held 20 bit periods → `bit_cnt` sticks at 15.
- **Sampling gated:** `dat_samp_en` = 0 with `RX_IN` toggling → `sampled_bit` unchanged and `sample_valid` never asserted.
- **Reset mid-frame:** assert `rst_n` low at `edge_cnt` 7, `bit_cnt` 3 → all outputs go immediately to their reset values (`sampled_bit` = 1). After release with `enable` high, `edge_cnt` restarts from 0.

Source files
------------

// File: rtl/rx_edge_bit_sampler_if.sv
// Bundle between the UART receive FSM side and the edge/bit sampler.
// The master drives the line and the controls, and the slave returns the counters and the sample.
interface rx_edge_bit_sampler_if #(
   parameter int EDGE_W = 6,
   parameter int BIT_W  = 4
);
   logic              RX_IN;
   logic              enable;
   logic              dat_samp_en;
   logic [EDGE_W-1:0] prescale;
   logic [EDGE_W-1:0] edge_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic              sampled_bit;
   logic              sample_valid;

   modport master (
      output RX_IN, enable, dat_samp_en, prescale,
      input  edge_cnt, bit_cnt, sampled_bit, sample_valid
   );

   modport slave (
      input  RX_IN, enable, dat_samp_en, prescale,
      output edge_cnt, bit_cnt, sampled_bit, sample_valid
   );
endinterface

// File: rtl/rx_edge_bit_sampler.sv
// UART receiver timing stage: counts oversampling edges and frame bits,
// and produces a 3-point majority-voted sample of RX_IN for each bit period.
module rx_edge_bit_sampler #(
   parameter int EDGE_W = 6,
   parameter int BIT_W  = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   rx_edge_bit_sampler_if.slave bus
);
   logic [EDGE_W-1:0] p_eff;
   logic [EDGE_W-1:0] half;
   logic              last_edge;
   logic              cap0, cap1, cap2;
   logic              s2_next;

   logic [EDGE_W-1:0] edge_q;
   logic [BIT_W-1:0]  bit_q;
   logic              s0, s1, s2;
   logic              samp_q;
   logic              valid_q;

   always_comb begin
      p_eff     = (bus.prescale < EDGE_W'(8)) ? EDGE_W'(8) : bus.prescale;
      half      = p_eff >> 1;
      last_edge = (edge_q == p_eff - EDGE_W'(1));
      cap0      = bus.dat_samp_en && (edge_q == half - EDGE_W'(3));
      cap1      = bus.dat_samp_en && (edge_q == half - EDGE_W'(2));
      cap2      = bus.dat_samp_en && (edge_q == half - EDGE_W'(1));
      // The third sample lands on the same edge as the vote, so vote on its incoming value.
      s2_next   = cap2 ? bus.RX_IN : s2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else if (!bus.enable) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else if (last_edge) begin
         edge_q <= '0;
         if (bit_q != '1)
            bit_q <= bit_q + BIT_W'(1);
      end else begin
         edge_q <= edge_q + EDGE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0      <= 1'b1;
         s1      <= 1'b1;
         s2      <= 1'b1;
         samp_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         if (cap0) s0 <= bus.RX_IN;
         if (cap1) s1 <= bus.RX_IN;
         s2      <= s2_next;
         valid_q <= cap2;
         if (cap2)
            samp_q <= (s0 & s1) | (s0 & s2_next) | (s1 & s2_next);
      end
   end

   assign bus.edge_cnt     = edge_q;
   assign bus.bit_cnt      = bit_q;
   assign bus.sampled_bit  = samp_q;
   assign bus.sample_valid = valid_q;
endmodule

// File: tb/tb_rx_edge_bit_sampler.sv
// Directed bench for rx_edge_bit_sampler: the stimulus queues the expected votes,
// and a monitor pops them on each sample_valid pulse and checks the voted value and its position.
module tb_rx_edge_bit_sampler;
   logic clk;
   logic rst_n;

   rx_edge_bit_sampler_if #(.EDGE_W(6), .BIT_W(4)) bus ();

   rx_edge_bit_sampler #(.EDGE_W(6), .BIT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic val;
      int   edge_pos;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic last_sampled = 1'b1;

   function automatic logic maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && bus.sample_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid=1 with edge_cnt=%0d, expected no pulse at %0t",
                     bus.edge_cnt, $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("sampled_bit", int'(bus.sampled_bit), int'(e.val));
            check("valid_edge", int'(bus.edge_cnt), e.edge_pos);
         end
      end
   end

   // One bit period, or its first ncyc cycles. samp[0..2] are placed on RX_IN at H-3..H-1.
   // All other cycles carry the opposite level, so a mistimed capture flips the vote.
   task automatic bit_period(input int pcfg, input logic samp_en, input logic [2:0] samp,
                             input int bidx, input int ncyc);
      int   p;
      int   h;
      logic m;
      p = (pcfg < 8) ? 8 : pcfg;
      h = p / 2;
      m = maj(samp[0], samp[1], samp[2]);
      if (samp_en) q.push_back('{m, h});
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk); #1;
         bus.enable      = 1'b1;
         bus.dat_samp_en = samp_en;
         bus.prescale    = 6'(pcfg);
         bus.RX_IN       = (i == h-3) ? samp[0] : (i == h-2) ? samp[1] :
                           (i == h-1) ? samp[2] : ~m;
         @(negedge clk);
         check("edge_cnt", int'(bus.edge_cnt), i);
         check("bit_cnt", int'(bus.bit_cnt), bidx);
         if (!samp_en) check("sampled_held", int'(bus.sampled_bit), int'(last_sampled));
      end
      if (samp_en && ncyc > h) last_sampled = m;
   endtask

   task automatic drop_enable();
      @(posedge clk); #1;
      bus.enable      = 1'b0;
      bus.dat_samp_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("edge_cnt_clear", int'(bus.edge_cnt), 0);
      check("bit_cnt_clear", int'(bus.bit_cnt), 0);
   endtask

   initial begin
      logic [9:0] frame;
      logic       b;
      logic [2:0] pat;

      rst_n           = 1'b0;
      bus.RX_IN       = 1'b1;
      bus.enable      = 1'b0;
      bus.dat_samp_en = 1'b0;
      bus.prescale    = 6'd16;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_edge_cnt", int'(bus.edge_cnt), 0);
      check("rst_bit_cnt", int'(bus.bit_cnt), 0);
      check("rst_sampled_bit", int'(bus.sampled_bit), 1);
      check("rst_sample_valid", int'(bus.sample_valid), 0);
      rst_n = 1'b1;

      // Basic count, P = 16
      for (int k = 0; k < 3; k++) bit_period(16, 1'b0, 3'b010, k, 16);
      drop_enable();

      // Majority vote, P = 8, then the same with prescale 4 (clamped to 8)
      bit_period(8, 1'b1, 3'b010, 0, 8);
      bit_period(8, 1'b1, 3'b101, 1, 8);
      bit_period(4, 1'b1, 3'b100, 2, 8);
      bit_period(4, 1'b1, 3'b011, 3, 8);
      drop_enable();

      // Frame 0xA5, P = 32: start, 8 data bits LSB first, stop
      frame = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         b = frame[k];
         case (k % 4)
            0:       pat = {b, b, b};
            1:       pat = {~b, b, b};
            2:       pat = {b, ~b, b};
            default: pat = {b, b, ~b};
         endcase
         bit_period(32, 1'b1, pat, k, 32);
      end
      drop_enable();

      // Sampling gated: RX_IN toggles but nothing is captured
      bit_period(16, 1'b0, 3'b000, 0, 16);
      bit_period(16, 1'b0, 3'b111, 1, 16);
      drop_enable();

      // bit_cnt saturation over 20 bit periods
      for (int k = 0; k < 20; k++) bit_period(8, 1'b0, 3'b010, (k < 15) ? k : 15, 8);
      drop_enable();

      // Reset mid-frame at edge_cnt 7 of bit 3, with sampled_bit at 0 beforehand
      for (int k = 0; k < 3; k++) bit_period(16, 1'b1, 3'b000, k, 16);
      bit_period(16, 1'b0, 3'b000, 3, 8);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_edge_cnt", int'(bus.edge_cnt), 0);
      check("midrst_bit_cnt", int'(bus.bit_cnt), 0);
      check("midrst_sampled_bit", int'(bus.sampled_bit), 1);
      check("midrst_sample_valid", int'(bus.sample_valid), 0);
      last_sampled = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      check("restart_edge_cnt", int'(bus.edge_cnt), 0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("restart_edge_cnt", int'(bus.edge_cnt), i);
         check("restart_bit_cnt", int'(bus.bit_cnt), 0);
      end
      drop_enable();

      repeat (2) @(negedge clk);
      check("scoreboard_empty", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
